music_sequencer: RTL
====================

Name: music_sequencer

Overview:
- Consumer of the song-selection interface: takes the 2-bit song index `select` and the one-cycle `start` pulse from the song-selection FSM.
- Walks that song's note words in the shared note ROM and presents the current note, with a duration measured in beat ticks.
- Sits between the song-selection FSM, the note ROM, and the tone generator.
- Loops the song until a new `start` arrives.

Parameters:
- IDX_BITS, 6, width of the note index within a song (64 words per song).
- NOTE_BITS, 4, width of the note code; code 0 = rest.
- DUR_BITS, 8, width of the duration field, in beat ticks; duration 0 = end-of-song marker.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- select  in  2  song index from the song-selection FSM; sampled only when start=1.
- start  in  1  one-cycle pulse: restart playback at note 0 of song `select`.
- tick  in  1  one-cycle beat pulse from the tempo divider.
- mem_addr  out  2+IDX_BITS  ROM address = {sel_r, idx}; sel_r is the MSBs.
- mem_data  in  NOTE_BITS+DUR_BITS  ROM word = {note, duration}; synchronous ROM, data valid 1 cycle after the address.
- note  out  NOTE_BITS  current note code to the tone generator.
- note_valid  out  1  high while a non-rest note is playing.
- song_end  out  1  one-cycle pulse when the song wraps to note 0.

Behaviour:
- Reset (async, immediate) forces:
  - state=IDLE, sel_r=0, idx=0, remaining=0
  - note=0, note_valid=0, song_end=0
  - mem_addr=0
- mem_addr is combinational from the registers sel_r and idx.
- States: IDLE, FETCH, LOAD, PLAY.
- `start` has priority in every state: sel_r<=select, idx<=0, remaining<=0, note_valid<=0, next state FETCH.
  - start and tick in the same cycle: start wins and the tick is ignored.
- IDLE: outputs held at reset values; waits for start.
- FETCH: 1 cycle, no actions. mem_addr is stable; ROM data is valid on the next cycle. Next state LOAD.
- LOAD: decode mem_data.
  - duration==0 and idx!=0: pulse song_end, idx<=0, next state FETCH (loop).
  - duration==0 and idx==0: empty song. note<=0, note_valid<=0, next state IDLE, no song_end.
  - otherwise: note<=mem_data note field, note_valid<=(note field!=0), remaining<=duration, next state PLAY.
- PLAY, tick=1:
  - remaining>1: remaining<=remaining-1.
  - remaining==1: advance and go to FETCH.
- Advance:
  - idx==all-ones: idx<=0 and pulse song_end.
  - otherwise: idx<=idx+1.
- During the FETCH/LOAD gap, note and note_valid keep the previous note (2-cycle hold).
- Timing:
  - start sampled at edge n → FETCH during n..n+1 → LOAD at n+2 → note/note_valid valid after edge n+2.
  - A note of duration D occupies exactly D ticks in PLAY plus the 2-cycle fetch gap.
- `select` changes without start are ignored (sel_r is latched only on start).
- `start` mid-note aborts the note immediately: note_valid drops the cycle after start and the new song is fetched.
- song_end is never asserted in the same cycle as start.
- `tick` outside PLAY is ignored.

Test Plan:
- Reset, then start with select=2, ROM[2:0]={5,3}, ROM[2:1]={7,1}, ROM[2:2]={0,0} → mem_addr=0x80; note=5, note_valid=1 for 3 ticks; then note=7 for 1 tick; song_end pulses once; mem_addr returns to 0x80 and note=5 plays again.
- Rest word {0,2} → note_valid=0 for 2 ticks while note=0; the next word plays normally.
- start asserted mid-note (remaining=4) with select=1 → note_valid=0 the next cycle; mem_addr=0x40; the first word of song 1 is loaded 2 cycles later; the old note never resumes.
- start and tick in the same cycle while remaining=1 → idx resets to 0 and is not advanced; song_end=0.
- Song 3 with 64 non-zero words and no end marker → after idx=63 completes, song_end pulses and mem_addr wraps 0xFF→0xC0.
- Empty song (ROM[x:0] duration=0) → state IDLE, note_valid=0, no song_end.
- Assert reset during PLAY (asynchronously, between clock edges) → all outputs are 0 immediately, before the next clk edge; no playback until the next start.

Source files
------------

// File: rtl/music_sequencer.sv
// music_sequencer: walks one song of the shared note ROM and presents the current note
// for a beat-tick duration, looping the song until a new start arrives.
`default_nettype none

module music_sequencer #(
  parameter int IDX_BITS  = 6,
  parameter int NOTE_BITS = 4,
  parameter int DUR_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    select,
  input  logic                          start,
  input  logic                          tick,
  output logic [2+IDX_BITS-1:0]         mem_addr,
  input  logic [NOTE_BITS+DUR_BITS-1:0] mem_data,
  output logic [NOTE_BITS-1:0]          note,
  output logic                          note_valid,
  output logic                          song_end
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            sel_r, sel_nxt;
  logic [IDX_BITS-1:0]   idx, idx_nxt;
  logic [DUR_BITS-1:0]   remaining, rem_nxt;
  logic [NOTE_BITS-1:0]  note_nxt;
  logic                  valid_nxt;
  logic                  end_nxt;

  logic [NOTE_BITS-1:0]  word_note;
  logic [DUR_BITS-1:0]   word_dur;

  assign word_note = mem_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
  assign word_dur  = mem_data[DUR_BITS-1:0];
  assign mem_addr  = {sel_r, idx};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel_r      <= '0;
      idx        <= '0;
      remaining  <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      song_end   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel_r      <= sel_nxt;
      idx        <= idx_nxt;
      remaining  <= rem_nxt;
      note       <= note_nxt;
      note_valid <= valid_nxt;
      song_end   <= end_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_r;
    idx_nxt   = idx;
    rem_nxt   = remaining;
    note_nxt  = note;
    valid_nxt = note_valid;
    end_nxt   = 1'b0;

    // start overrides whatever the FSM was doing, including a tick in the same cycle
    if (start) begin
      sel_nxt   = select;
      idx_nxt   = '0;
      rem_nxt   = '0;
      valid_nxt = 1'b0;
      state_nxt = FETCH;
    end else begin
      unique case (state)
        IDLE:  state_nxt = IDLE;
        FETCH: state_nxt = LOAD;
        LOAD: begin
          if (word_dur == '0) begin
            if (idx != '0) begin
              end_nxt   = 1'b1;
              idx_nxt   = '0;
              state_nxt = FETCH;
            end else begin
              note_nxt  = '0;
              valid_nxt = 1'b0;
              state_nxt = IDLE;
            end
          end else begin
            note_nxt  = word_note;
            valid_nxt = (word_note != '0);
            rem_nxt   = word_dur;
            state_nxt = PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            if (remaining > DUR_BITS'(1)) begin
              rem_nxt = remaining - 1'b1;
            end else begin
              // idx wraps naturally past all-ones; that wrap is the end of the song
              rem_nxt   = '0;
              idx_nxt   = idx + 1'b1;
              end_nxt   = &idx;
              state_nxt = FETCH;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
